// File: rtl/rgb_led_ctrl_pkg.sv
// Shared constants for the RGB LED sequencer: channel state encodings, switch field
// positions, button roles and default timing parameters.
package rgb_led_ctrl_pkg;

  typedef logic [1:0] ch_state_t;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_ON    = 2'd1;
  localparam logic [1:0] ST_BLINK = 2'd2;

  localparam int DB_CYCLES_DEF  = 1_000_000;
  localparam int BLINK_HALF_DEF = 25_000_000;
  localparam int PWM_BITS_DEF   = 8;

  localparam int COL_W       = 3;
  localparam int CH0_COL_LSB = 0;
  localparam int CH1_COL_LSB = 13;
  localparam int DUTY_LSB    = 3;

  localparam int BTN_CH0  = 0;
  localparam int BTN_CH1  = 1;
  localparam int BTN_DUTY = 2;
  localparam int BTN_CLR  = 3;
  localparam int NUM_BTN  = 4;

  function automatic ch_state_t ch_next(input ch_state_t st);
    case (st)
      ST_OFF:   ch_next = ST_ON;
      ST_ON:    ch_next = ST_BLINK;
      ST_BLINK: ch_next = ST_OFF;
      default:  ch_next = ST_OFF;
    endcase
  endfunction

  // A channel is lit when ON, or when BLINK during the bright half-period.
  function automatic logic ch_lit(input ch_state_t st, input logic phase);
    ch_lit = (st == ST_ON) | ((st == ST_BLINK) & phase);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-FF synchroniser, stability counter and a one-cycle
// pulse on each accepted press (released edges produce nothing).
module btn_debounce
  import rgb_led_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic press,
  output logic level
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          stable_q;
  logic          stable_d;
  logic          stable_dly_q;
  logic          press_q;

  // Bring the raw pin into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles of disagreement; accept the new level once the run is long enough.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d    = {CW{1'b0}};
        stable_d = sync2_q;
      end else begin
        cnt_d    = cnt_q + CW'(1);
        stable_d = stable_q;
      end
    end else begin
      cnt_d    = {CW{1'b0}};
      stable_d = stable_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= {CW{1'b0}};
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
    end
  end

  assign press = press_q;
  assign level = stable_q;

endmodule

// File: rtl/rgb_led_ctrl.sv
// Sequencer for two RGB LEDs and the user LED bank: per-channel OFF/ON/BLINK state,
// switch-latched colours, shared PWM brightness and blink timebase.
module rgb_led_ctrl
  import rgb_led_ctrl_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int BLINK_HALF = BLINK_HALF_DEF,
  parameter int PWM_BITS   = PWM_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn,
  input  logic [15:0] sw,
  output logic [2:0]  rgb0,
  output logic [2:0]  rgb1,
  output logic [15:0] led
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [NUM_BTN-1:0]  press_s;
  logic [NUM_BTN-1:0]  level_s;
  logic [15:0]         sw_meta_q;
  logic [15:0]         sw_sync_q;

  ch_state_t           st0_q;
  ch_state_t           st0_d;
  ch_state_t           st1_q;
  ch_state_t           st1_d;
  logic [COL_W-1:0]    col0_q;
  logic [COL_W-1:0]    col0_d;
  logic [COL_W-1:0]    col1_q;
  logic [COL_W-1:0]    col1_d;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_d;

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [BW-1:0]       blink_cnt_q;
  logic                phase_q;
  logic                pwm_on_s;
  logic [7:0]          duty_led_s;

  logic [2:0]          rgb0_q;
  logic [2:0]          rgb1_q;
  logic [15:0]         led_q;
  logic                unused_s;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (btn[gi]),
      .press (press_s[gi]),
      .level (level_s[gi])
    );
  end

  assign unused_s = ^{level_s, sw_sync_q};

  // Switch synchroniser; colours and duty are only ever sampled from the synced copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= 16'h0000;
      sw_sync_q <= 16'h0000;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Channel FSMs, colour latches and duty; global clear overrides channel presses.
  always_comb begin
    st0_d  = st0_q;
    st1_d  = st1_q;
    col0_d = col0_q;
    col1_d = col1_q;
    duty_d = duty_q;
    if (press_s[BTN_CLR]) begin
      st0_d  = ST_OFF;
      st1_d  = ST_OFF;
      col0_d = {COL_W{1'b0}};
      col1_d = {COL_W{1'b0}};
    end else begin
      if (press_s[BTN_CH0]) begin
        st0_d = ch_next(st0_q);
        if (st0_q == ST_OFF) begin
          col0_d = sw_sync_q[CH0_COL_LSB +: COL_W];
        end else begin
          col0_d = col0_q;
        end
      end else begin
        st0_d = st0_q;
      end
      if (press_s[BTN_CH1]) begin
        st1_d = ch_next(st1_q);
        if (st1_q == ST_OFF) begin
          col1_d = sw_sync_q[CH1_COL_LSB +: COL_W];
        end else begin
          col1_d = col1_q;
        end
      end else begin
        st1_d = st1_q;
      end
    end
    if (press_s[BTN_DUTY]) begin
      duty_d = sw_sync_q[DUTY_LSB +: PWM_BITS];
    end else begin
      duty_d = duty_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0_q  <= ST_OFF;
      st1_q  <= ST_OFF;
      col0_q <= {COL_W{1'b0}};
      col1_q <= {COL_W{1'b0}};
      duty_q <= {PWM_BITS{1'b1}};
    end else begin
      st0_q  <= st0_d;
      st1_q  <= st1_d;
      col0_q <= col0_d;
      col1_q <= col1_d;
      duty_q <= duty_d;
    end
  end

  // Free-running timebases; blink is shared and never restarted on BLINK entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q   <= {PWM_BITS{1'b0}};
      blink_cnt_q <= {BW{1'b0}};
      phase_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= {BW{1'b0}};
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
        phase_q     <= phase_q;
      end
    end
  end

  assign pwm_on_s   = (pwm_cnt_q < duty_q) | (&duty_q);
  assign duty_led_s = 8'(duty_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb0_q <= 3'b000;
      rgb1_q <= 3'b000;
      led_q  <= 16'h0000;
    end else begin
      rgb0_q <= (ch_lit(st0_q, phase_q) & pwm_on_s) ? col0_q : 3'b000;
      rgb1_q <= (ch_lit(st1_q, phase_q) & pwm_on_s) ? col1_q : 3'b000;
      led_q  <= {st1_q, st0_q, 4'b0000, duty_led_s};
    end
  end

  assign rgb0 = rgb0_q;
  assign rgb1 = rgb1_q;
  assign led  = led_q;

endmodule
